// File: rtl/touch_frame_assembler_pkg.sv
// Shared constants, FSM encoding and coordinate decode for the touch frame assembler.
// Define TOUCH_CLAMP_EN to clamp decoded coordinates to the panel resolution.
package touch_frame_assembler_pkg;

    localparam logic [3:0] FRAME_LEN  = 4'd10;
    localparam logic [7:0] START_ADDR = 8'h10;
    localparam int         H_RES      = 800;
    localparam int         V_RES      = 480;

    localparam int OFS_GESTURE = 0;
    localparam int OFS_COUNT   = 1;
    localparam int OFS_X1H     = 2;
    localparam int OFS_X1L     = 3;
    localparam int OFS_Y1H     = 4;
    localparam int OFS_Y1L     = 5;
    localparam int OFS_X2H     = 6;
    localparam int OFS_X2L     = 7;
    localparam int OFS_Y2H     = 8;
    localparam int OFS_Y2L     = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RECV,
        ST_CHECK,
        ST_PUBLISH,
        ST_HOLD,
        ST_DROP
    } state_t;

    function automatic logic [9:0] decode_x(input logic [11:0] raw);
        logic [11:0] v;
        v = raw;
`ifdef TOUCH_CLAMP_EN
        if (v > 12'(H_RES - 1))
            v = 12'(H_RES - 1);
`endif
        return 10'(v);
    endfunction

    function automatic logic [8:0] decode_y(input logic [11:0] raw);
        logic [11:0] v;
        v = raw;
`ifdef TOUCH_CLAMP_EN
        if (v > 12'(V_RES - 1))
            v = 12'(V_RES - 1);
`endif
        return 9'(v);
    endfunction

endpackage

// File: rtl/touch_frame_assembler_if.sv
// Burst-reader handshake plus published frame registers of the touch frame assembler.
interface touch_frame_assembler_if;

    logic       oRD_REQ;
    logic [7:0] oRD_ADDR;
    logic [3:0] oRD_LEN;
    logic       iRD_ACK;
    logic       iBYTE_VALID;
    logic [7:0] iBYTE;
    logic       iRD_DONE;
    logic       iRD_ERR;

    logic       oREADY;
    logic [9:0] oREG_X1;
    logic [9:0] oREG_X2;
    logic [8:0] oREG_Y1;
    logic [8:0] oREG_Y2;
    logic [1:0] oREG_TOUCH_COUNT;
    logic [7:0] oREG_GESTURE;
    logic [7:0] oERR_CNT;

    modport master (
        output oRD_REQ, oRD_ADDR, oRD_LEN,
        input  iRD_ACK, iBYTE_VALID, iBYTE,
        input  iRD_DONE, iRD_ERR,
        output oREADY, oREG_X1, oREG_X2,
        output oREG_Y1, oREG_Y2,
        output oREG_TOUCH_COUNT, oREG_GESTURE,
        output oERR_CNT
    );

    modport slave (
        input  oRD_REQ, oRD_ADDR, oRD_LEN,
        output iRD_ACK, iBYTE_VALID, iBYTE,
        output iRD_DONE, iRD_ERR,
        input  oREADY, oREG_X1, oREG_X2,
        input  oREG_Y1, oREG_Y2,
        input  oREG_TOUCH_COUNT, oREG_GESTURE,
        input  oERR_CNT
    );

endinterface

// File: rtl/touch_frame_assembler_int_sync.sv
// Two-flop synchroniser and falling-edge detector for the panel interrupt.
module touch_frame_assembler_int_sync (
    input  logic iCLK,
    input  logic iRSTN,
    input  logic iTOUCH_INT,
    output logic int_sync,
    output logic int_fall
);

    logic meta;
    logic sync;
    logic prev;

    // Idle level of the interrupt is high, so reset to 1 to avoid a false edge.
    always_ff @(posedge iCLK) begin
        if (!iRSTN) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= iTOUCH_INT;
            sync <= meta;
            prev <= sync;
        end
    end

    assign int_sync = sync;
    assign int_fall = prev & ~sync;

endmodule

// File: rtl/touch_frame_assembler.sv
// Polls the touch panel on interrupt, assembles one register burst into a frame.
// Optional TOUCH_CLAMP_EN build macro clamps coordinates (see package).
module touch_frame_assembler
    import touch_frame_assembler_pkg::*;
#(
    parameter int          READY_HOLD = 4,
    parameter logic [19:0] POLL_GAP   = 20'd50000,
    parameter logic [19:0] TIMEOUT    = 20'd200000
) (
    input  logic iCLK,
    input  logic iRSTN,
    input  logic iTOUCH_INT,
    touch_frame_assembler_if.master bus
);

    localparam logic [3:0] HOLD_LAST = 4'(READY_HOLD - 1);

    state_t      state;
    logic [7:0]  frame [FRAME_LEN];
    logic [3:0]  idx;
    logic        ovf;
    logic [19:0] gap_cnt;
    logic [19:0] tmo_cnt;
    logic [3:0]  hold_cnt;
    logic        int_sync;
    logic        int_fall;

    touch_frame_assembler_int_sync u_sync (
        .iCLK       (iCLK),
        .iRSTN      (iRSTN),
        .iTOUCH_INT (iTOUCH_INT),
        .int_sync   (int_sync),
        .int_fall   (int_fall)
    );

    assign bus.oRD_ADDR = START_ADDR;
    assign bus.oRD_LEN  = FRAME_LEN;

    always_ff @(posedge iCLK) begin
        if (!iRSTN) begin
            state                <= ST_IDLE;
            idx                  <= '0;
            ovf                  <= 1'b0;
            gap_cnt              <= '0;
            tmo_cnt              <= '0;
            hold_cnt             <= '0;
            bus.oRD_REQ          <= 1'b0;
            bus.oREADY           <= 1'b0;
            bus.oREG_X1          <= '0;
            bus.oREG_X2          <= '0;
            bus.oREG_Y1          <= '0;
            bus.oREG_Y2          <= '0;
            bus.oREG_TOUCH_COUNT <= '0;
            bus.oREG_GESTURE     <= '0;
            bus.oERR_CNT         <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (int_sync) begin
                        gap_cnt <= '0;
                    end else if (int_fall ||
                                 gap_cnt + 20'd1 == POLL_GAP) begin
                        state       <= ST_REQ;
                        bus.oRD_REQ <= 1'b1;
                        gap_cnt     <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 20'd1;
                    end
                end
                ST_REQ: begin
                    if (bus.iRD_ACK) begin
                        state       <= ST_RECV;
                        bus.oRD_REQ <= 1'b0;
                        idx         <= '0;
                        ovf         <= 1'b0;
                        tmo_cnt     <= '0;
                    end
                end
                ST_RECV: begin
                    // A byte arriving with DONE is still captured before CHECK.
                    if (bus.iBYTE_VALID) begin
                        if (idx < FRAME_LEN) begin
                            frame[idx] <= bus.iBYTE;
                            idx        <= idx + 4'd1;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                    if (bus.iRD_ERR || tmo_cnt == TIMEOUT)
                        state <= ST_DROP;
                    else if (bus.iRD_DONE)
                        state <= ST_CHECK;
                    else
                        tmo_cnt <= tmo_cnt + 20'd1;
                end
                ST_CHECK: begin
                    // Registers load here so they settle a cycle ahead of oREADY.
                    if (idx == FRAME_LEN && !ovf) begin
                        state <= ST_PUBLISH;
                        bus.oREG_GESTURE     <= frame[OFS_GESTURE];
                        bus.oREG_TOUCH_COUNT <= frame[OFS_COUNT][1:0];
                        bus.oREG_X1 <= decode_x({frame[OFS_X1H][3:0],
                                                 frame[OFS_X1L]});
                        bus.oREG_Y1 <= decode_y({frame[OFS_Y1H][3:0],
                                                 frame[OFS_Y1L]});
                        bus.oREG_X2 <= decode_x({frame[OFS_X2H][3:0],
                                                 frame[OFS_X2L]});
                        bus.oREG_Y2 <= decode_y({frame[OFS_Y2H][3:0],
                                                 frame[OFS_Y2L]});
                    end else begin
                        state <= ST_DROP;
                    end
                end
                ST_PUBLISH: begin
                    bus.oREADY <= 1'b1;
                    hold_cnt   <= '0;
                    state      <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        bus.oREADY <= 1'b0;
                        gap_cnt    <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                ST_DROP: begin
                    if (bus.oERR_CNT != 8'hFF)
                        bus.oERR_CNT <= bus.oERR_CNT + 8'd1;
                    gap_cnt <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_touch_frame_assembler.sv
// Scoreboard bench for touch_frame_assembler: bursts, drops, polling, timeout, reset.
`timescale 1ns/1ps
module tb_touch_frame_assembler;

    localparam int P_GAP  = 40;
    localparam int P_TMO  = 100;
    localparam int P_HOLD = 4;

    typedef logic [7:0] burst_t [10];

    typedef struct {
        logic [9:0] x1;
        logic [8:0] y1;
        logic [9:0] x2;
        logic [8:0] y2;
        logic [1:0] cnt;
        logic [7:0] ges;
    } frm_t;

    logic iCLK = 1'b0;
    logic iRSTN = 1'b0;
    logic iTOUCH_INT = 1'b1;

    touch_frame_assembler_if u_if ();

    touch_frame_assembler #(
        .READY_HOLD (P_HOLD),
        .POLL_GAP   (20'(P_GAP)),
        .TIMEOUT    (20'(P_TMO))
    ) dut (
        .iCLK       (iCLK),
        .iRSTN      (iRSTN),
        .iTOUCH_INT (iTOUCH_INT),
        .bus        (u_if)
    );

    always #5 iCLK = ~iCLK;

    int   errs   = 0;
    int   checks = 0;
    frm_t exp_q [$];
    frm_t e;
    logic prev_rdy = 1'b0;
    int   width = 0;
    logic [9:0] last_x1 = '0;
    bit   seen;
    int   n;
    burst_t fa;
    burst_t fc;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] mx(input int raw);
        int v;
        v = raw;
`ifdef TOUCH_CLAMP_EN
        if (v > 799) v = 799;
`endif
        return 10'(v);
    endfunction

    function automatic logic [8:0] my(input int raw);
        int v;
        v = raw;
`ifdef TOUCH_CLAMP_EN
        if (v > 479) v = 479;
`endif
        return 9'(v);
    endfunction

    function automatic frm_t model(input burst_t b);
        frm_t f;
        f.ges = b[0];
        f.cnt = b[1][1:0];
        f.x1  = mx(int'({b[2][3:0], b[3]}));
        f.y1  = my(int'({b[4][3:0], b[5]}));
        f.x2  = mx(int'({b[6][3:0], b[7]}));
        f.y2  = my(int'({b[8][3:0], b[9]}));
        return f;
    endfunction

    // Output monitor: every oREADY rise pops one expected frame.
    always @(negedge iCLK) begin
        if (u_if.oREADY && !prev_rdy) begin
            chk("reg_stable_x1", u_if.oREG_X1, last_x1);
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("x1", u_if.oREG_X1, e.x1);
                chk("y1", u_if.oREG_Y1, e.y1);
                chk("x2", u_if.oREG_X2, e.x2);
                chk("y2", u_if.oREG_Y2, e.y2);
                chk("count", u_if.oREG_TOUCH_COUNT, e.cnt);
                chk("gesture", u_if.oREG_GESTURE, e.ges);
            end
            width = 1;
        end else if (u_if.oREADY) begin
            width++;
        end else if (prev_rdy) begin
            chk("ready_width", width, P_HOLD);
        end
        prev_rdy = u_if.oREADY;
        last_x1  = u_if.oREG_X1;
    end

    task automatic tick(input int k);
        repeat (k) @(negedge iCLK);
    endtask

    task automatic wait_req(input int budget);
        bit s;
        s = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge iCLK);
            if (u_if.oRD_REQ) begin
                s = 1;
                break;
            end
        end
        chk("req_seen", s, 1);
    endtask

    task automatic wait_ready_fall(input int budget);
        bit p;
        bit d;
        p = 0;
        d = 0;
        for (int i = 0; i < budget && !d; i++) begin
            @(negedge iCLK);
            if (p && !u_if.oREADY) d = 1;
            p = u_if.oREADY;
        end
        chk("ready_fall_seen", d, 1);
    endtask

    // mode 0: DONE after bytes, 1: DONE with last byte, 2: no DONE
    task automatic serve(input burst_t b, input int nb,
                         input int mode, input int err_after);
        tick(3);
        chk("req_held", u_if.oRD_REQ, 1);
        u_if.iRD_ACK = 1'b1;
        @(negedge iCLK);
        u_if.iRD_ACK = 1'b0;
        chk("req_clr_on_ack", u_if.oRD_REQ, 0);
        for (int i = 0; i < nb; i++) begin
            if (err_after == i) begin
                u_if.iRD_ERR = 1'b1;
                @(negedge iCLK);
                u_if.iRD_ERR = 1'b0;
                return;
            end
            u_if.iBYTE_VALID = 1'b1;
            u_if.iBYTE       = b[i];
            u_if.iRD_DONE    = (mode == 1 && i == nb - 1);
            @(negedge iCLK);
        end
        u_if.iBYTE_VALID = 1'b0;
        u_if.iRD_DONE    = 1'b0;
        if (mode == 0) begin
            u_if.iRD_DONE = 1'b1;
            @(negedge iCLK);
            u_if.iRD_DONE = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        fa = '{8'h00, 8'h02, 8'h01, 8'h2C, 8'h00,
               8'hF0, 8'h02, 8'h58, 8'h01, 8'h90};
        fc = '{8'h05, 8'h01, 8'h03, 8'hFF, 8'h01,
               8'hF0, 8'h00, 8'h10, 8'h00, 8'h20};
        u_if.iRD_ACK     = 1'b0;
        u_if.iBYTE_VALID = 1'b0;
        u_if.iBYTE       = 8'h00;
        u_if.iRD_DONE    = 1'b0;
        u_if.iRD_ERR     = 1'b0;
        tick(3);
        chk("rst_req", u_if.oRD_REQ, 0);
        chk("rst_ready", u_if.oREADY, 0);
        chk("rst_err", u_if.oERR_CNT, 0);
        chk("rst_addr", u_if.oRD_ADDR, 8'h10);
        chk("rst_len", u_if.oRD_LEN, 10);
        chk("rst_x1", u_if.oREG_X1, 0);
        iRSTN = 1'b1;
        tick(5);

        // Basic burst, DONE in its own cycle
        iTOUCH_INT = 1'b0;
        wait_req(10);
        exp_q.push_back(model(fa));
        serve(fa, 10, 0, -1);
        wait_ready_fall(30);

        // INT still low: re-poll after POLL_GAP, DONE on last byte
        n = 0;
        for (int i = 0; i < 3 * P_GAP; i++) begin
            @(negedge iCLK);
            n++;
            if (u_if.oRD_REQ) break;
        end
        chk("poll_gap", n, P_GAP);
        exp_q.push_back(model(fa));
        serve(fa, 10, 1, -1);
        wait_ready_fall(30);

        // INT released: no further polls
        iTOUCH_INT = 1'b1;
        seen = 0;
        for (int i = 0; i < 3 * P_GAP; i++) begin
            @(negedge iCLK);
            if (u_if.oRD_REQ) seen = 1;
        end
        chk("no_poll", seen, 0);

        // Short burst (9 bytes) is dropped
        iTOUCH_INT = 1'b0;
        wait_req(10);
        iTOUCH_INT = 1'b1;
        serve(fa, 9, 0, -1);
        tick(5);
        chk("short_err_cnt", u_if.oERR_CNT, 1);
        chk("short_keep_x1", u_if.oREG_X1, 300);

        // Bus error after byte 4 is dropped, registers retained
        iTOUCH_INT = 1'b0;
        wait_req(10);
        iTOUCH_INT = 1'b1;
        serve(fa, 10, 0, 4);
        tick(5);
        chk("err_err_cnt", u_if.oERR_CNT, 2);
        chk("err_keep_y1", u_if.oREG_Y1, 240);
        chk("err_keep_x2", u_if.oREG_X2, 600);
        chk("err_keep_y2", u_if.oREG_Y2, 400);

        // Out-of-range coordinates
        iTOUCH_INT = 1'b0;
        wait_req(10);
        iTOUCH_INT = 1'b1;
        exp_q.push_back(model(fc));
        serve(fc, 10, 0, -1);
        wait_ready_fall(30);
`ifdef TOUCH_CLAMP_EN
        chk("clamp_x1", u_if.oREG_X1, 799);
        chk("clamp_y1", u_if.oREG_Y1, 479);
`else
        chk("raw_x1", u_if.oREG_X1, 1023);
        chk("raw_y1", u_if.oREG_Y1, 496);
`endif

        // Missing DONE: timeout drop
        iTOUCH_INT = 1'b0;
        wait_req(10);
        iTOUCH_INT = 1'b1;
        serve(fc, 0, 2, -1);
        tick(P_TMO - 5);
        chk("tmo_not_early", u_if.oERR_CNT, 2);
        tick(15);
        chk("tmo_err_cnt", u_if.oERR_CNT, 3);

        // Reset while receiving
        iTOUCH_INT = 1'b0;
        wait_req(10);
        iTOUCH_INT = 1'b1;
        serve(fa, 4, 2, -1);
        iRSTN = 1'b0;
        @(negedge iCLK);
        chk("rrst_req", u_if.oRD_REQ, 0);
        chk("rrst_ready", u_if.oREADY, 0);
        chk("rrst_x1", u_if.oREG_X1, 0);
        chk("rrst_err", u_if.oERR_CNT, 0);
        iRSTN = 1'b1;
        u_if.iRD_ACK = 1'b1;
        @(negedge iCLK);
        u_if.iRD_ACK = 1'b0;
        for (int i = 4; i < 10; i++) begin
            u_if.iBYTE_VALID = 1'b1;
            u_if.iBYTE       = fa[i];
            u_if.iRD_DONE    = (i == 9);
            @(negedge iCLK);
        end
        u_if.iBYTE_VALID = 1'b0;
        u_if.iRD_DONE    = 1'b0;
        tick(20);
        chk("post_rst_ready", u_if.oREADY, 0);
        chk("post_rst_req", u_if.oRD_REQ, 0);
        chk("post_rst_err", u_if.oERR_CNT, 0);
        chk("post_rst_gesture", u_if.oREG_GESTURE, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
